// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and load-use hazard detection for the
// pipelined core. A shift-register scoreboard holds one entry per post-EX
// stage (index 0 = stage 1 = EX/MEM). For each EX source operand it selects
// the youngest in-flight producer. It raises a stall when that producer is a
// load whose data is not yet available.
// Optional build macro: FWD_STATS_EN adds stall_cnt / fwd_cnt counters.
module fwd_scoreboard #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STAGE = 2,
    localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_hold,
    input  logic                      ex_valid,
    input  logic                      ex_we,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_SRC-1:0]        ex_rs_used,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      hazard_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               fwd_cnt
`endif
);

    // A load cannot become forwardable later than the last tracked stage.
    localparam int unsigned LS_EFF = (LOAD_STAGE > FWD_DEPTH) ? FWD_DEPTH : LOAD_STAGE;

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t ent_q [FWD_DEPTH];
    entry_t ent_d [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_raw;
    logic [NUM_SRC-1:0]       op_wait;
    logic                     stall_raw;

    // Per operand: scan oldest to youngest so the youngest match is the one kept.
    always_comb begin
        sel_raw = '0;
        op_wait = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = FWD_DEPTH; k >= 1; k--) begin
                if (ex_valid && ex_rs_used[i] &&
                    ent_q[k-1].v && ent_q[k-1].we &&
                    (ent_q[k-1].rd == ex_rs[i*REG_AW +: REG_AW]) &&
                    (ex_rs[i*REG_AW +: REG_AW] != '0)) begin
                    sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k);
                    op_wait[i] = ent_q[k-1].ld && (k < LS_EFF);
                end
            end
        end
        stall_raw = |op_wait;
    end

    // Outputs are forced quiet in the same cycle reset is asserted.
    always_comb begin
        fwd_sel      = rst ? '0 : sel_raw;
        hazard_stall = !rst && stall_raw;
    end

    // Next scoreboard contents: hold, or shift with a bubble or the EX instruction in stage 1.
    always_comb begin
        for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            ent_d[k] = ent_q[k];
        end
        if (!pipe_hold) begin
            for (int unsigned k = FWD_DEPTH - 1; k >= 1; k--) begin
                ent_d[k] = ent_q[k-1];
            end
            if (stall_raw) begin
                ent_d[0] = '0;
            end else begin
                ent_d[0] = {ex_valid, ex_we, ex_is_load, ex_rd};
            end
        end
    end

    // Scoreboard register with synchronous clear.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            if (rst) begin
                ent_q[k] <= '0;
            end else begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

`ifdef FWD_STATS_EN
    localparam int unsigned CW = $clog2(NUM_SRC + 1);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [CW-1:0] nfwd;
    logic [32:0]   fwd_sum;

    // Saturating event counters for stalls and forwarded operands.
    always_comb begin
        nfwd = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            nfwd = nfwd + CW'(sel_raw[i*SEL_W +: SEL_W] != '0);
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_raw && !pipe_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        fwd_sum   = {1'b0, fwd_cnt_q} + 33'(nfwd);
        fwd_cnt_d = fwd_cnt_q;
        if (!stall_raw && !pipe_hold && ex_valid) begin
            fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: default configuration plus a
// 3-operand, 3-stage, LOAD_STAGE=3 instance.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals
    logic       rst, hold, ev, we, ld;
    logic [4:0] rd;
    logic [9:0] rs;
    logic [1:0] used;
    logic [3:0] sel;
    logic       stall;

    // Deep instance signals
    logic        d_hold, d_ev, d_we, d_ld;
    logic [4:0]  d_rd;
    logic [14:0] d_rs;
    logic [2:0]  d_used;
    logic [5:0]  d_sel;
    logic        d_stall;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt, d_stall_cnt, d_fwd_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_scoreboard u_dut (
        .clk(clk), .rst(rst), .pipe_hold(hold), .ex_valid(ev), .ex_we(we),
        .ex_is_load(ld), .ex_rd(rd), .ex_rs(rs), .ex_rs_used(used),
        .fwd_sel(sel), .hazard_stall(stall)
`ifdef FWD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    fwd_scoreboard #(.NUM_SRC(3), .FWD_DEPTH(3), .REG_AW(5), .LOAD_STAGE(3)) u_deep (
        .clk(clk), .rst(rst), .pipe_hold(d_hold), .ex_valid(d_ev), .ex_we(d_we),
        .ex_is_load(d_ld), .ex_rd(d_rd), .ex_rs(d_rs), .ex_rs_used(d_used),
        .fwd_sel(d_sel), .hazard_stall(d_stall)
`ifdef FWD_STATS_EN
        , .stall_cnt(d_stall_cnt), .fwd_cnt(d_fwd_cnt)
`endif
    );

    typedef struct {
        bit         r, h, v, w, l;
        logic [4:0] rd, rs0, rs1;
        logic [1:0] u;
        logic [3:0] sel;
        bit         st;
    } step_t;

    typedef struct {
        logic [3:0] sel;
        bit         st;
    } exp_t;

    typedef struct {
        logic [5:0] sel;
        bit         st;
    } dexp_t;

    exp_t  exp_q[$];
    dexp_t dexp_q[$];

    // Build one stimulus step: rst, hold, valid, we, load, rd, rs0, rs1, used, exp sel0, exp sel1, exp stall
    function automatic step_t mk(int r, int h, int v, int w, int l, int rd_, int a, int b,
                                 int u, int s0, int s1, int st);
        step_t m;
        m.r = r[0]; m.h = h[0]; m.v = v[0]; m.w = w[0]; m.l = l[0];
        m.rd = rd_[4:0]; m.rs0 = a[4:0]; m.rs1 = b[4:0]; m.u = u[1:0];
        m.sel = {s1[1:0], s0[1:0]};
        m.st = st[0];
        return m;
    endfunction

    // Apply a step to the default instance and queue its expected response
    task automatic drive(input step_t s);
        exp_t e;
        rst = s.r; hold = s.h; ev = s.v; we = s.w; ld = s.l;
        rd = s.rd; rs = {s.rs1, s.rs0}; used = s.u;
        e.sel = s.sel; e.st = s.st;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,1,1,1,5,5,5,3,0,0,0));
        s.push_back(mk(0,0,1,0,0,0,5,5,3,0,0,0));
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL reset[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL reset[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_forward();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        s.push_back(mk(0,0,1,1,0,5,1,2,3,0,0,0));   // add x5
        s.push_back(mk(0,0,1,1,0,6,5,7,3,1,0,0));   // sub x6,x5,x7
        s.push_back(mk(0,0,1,1,0,9,5,6,3,2,1,0));   // x5 now in stage 2, x6 in stage 1
        s.push_back(mk(0,0,0,0,0,0,6,9,3,0,0,0));   // ex_valid=0 -> nothing
        s.push_back(mk(0,0,1,0,0,0,6,9,1,0,0,0));   // x9 in stage 2 but operand 1 unused
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL alu_fwd[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL alu_fwd[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        s.push_back(mk(0,0,1,1,1,5,2,0,1,0,0,0));   // lw x5
        s.push_back(mk(0,0,1,1,0,8,5,5,3,1,1,1));   // add x8,x5,x5 -> stall
        s.push_back(mk(0,0,1,1,0,8,5,5,3,2,2,0));   // after bubble
        s.push_back(mk(0,0,1,0,0,0,8,0,1,1,0,0));   // x8 in stage 1
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL load_use[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL load_use[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        s.push_back(mk(0,0,1,1,1,3,0,0,0,0,0,0));   // lw x3
        s.push_back(mk(0,0,1,1,0,3,0,0,0,0,0,0));   // add x3
        s.push_back(mk(0,0,1,1,0,0,3,3,3,1,1,0));   // read x3 (ALU in 1, load in 2); writes x0
        s.push_back(mk(0,0,1,1,0,4,0,0,3,0,0,0));   // read x0 with x0 producer in stage 1
        s.push_back(mk(0,0,1,1,0,7,0,0,0,0,0,0));   // add x7
        s.push_back(mk(0,0,1,1,1,7,0,0,0,0,0,0));   // lw x7
        s.push_back(mk(0,0,1,0,0,0,7,0,1,1,0,1));   // youngest is unready load -> stall
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL youngest[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL youngest[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pipe_hold();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        s.push_back(mk(0,0,1,1,1,5,0,0,0,0,0,0));   // lw x5
        s.push_back(mk(0,1,1,1,0,8,5,0,1,1,0,1));   // held
        s.push_back(mk(0,1,1,1,0,8,5,0,1,1,0,1));
        s.push_back(mk(0,1,1,1,0,8,5,0,1,1,0,1));
        s.push_back(mk(0,0,1,1,0,8,5,0,1,1,0,1));   // released, bubble goes in
        s.push_back(mk(0,0,1,1,0,8,5,0,1,2,0,0));
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL pipe_hold[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL pipe_hold[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        s.push_back(mk(0,0,1,1,1,5,0,0,0,0,0,0));   // lw x5
        s.push_back(mk(0,1,1,1,0,8,5,5,3,1,1,1));   // stalled use (held so load stays in stage 1)
        s.push_back(mk(1,0,1,1,0,8,5,5,3,0,0,0));   // rst -> outputs quiet same cycle
        s.push_back(mk(0,0,1,1,0,8,5,5,3,0,0,0));   // entries empty
        foreach (s[j]) begin
            drive(s[j]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("FAIL mid_reset[%0d] fwd_sel got=%h exp=%h", j, sel, e.sel);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL mid_reset[%0d] hazard_stall got=%b exp=%b", j, stall, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_deep();
        // columns: rst, valid, we, load, rd, rs2, used, exp sel2, exp stall
        int    tbl[6][9] = '{
            '{1,0,0,0,0,0,0,0,0},
            '{0,1,1,1,9,0,0,0,0},
            '{0,1,0,0,0,9,4,1,1},
            '{0,1,0,0,0,9,4,2,1},
            '{0,1,0,0,0,9,4,3,0},
            '{0,0,0,0,0,0,0,0,0}};
        dexp_t e;
        for (int j = 0; j < 6; j++) begin
            rst = tbl[j][0][0]; d_hold = 1'b0; d_ev = tbl[j][1][0];
            d_we = tbl[j][2][0]; d_ld = tbl[j][3][0]; d_rd = tbl[j][4][4:0];
            d_rs = {tbl[j][5][4:0], 5'd2, 5'd1}; d_used = tbl[j][6][2:0];
            e.sel = {tbl[j][7][1:0], 4'b0000}; e.st = tbl[j][8][0];
            dexp_q.push_back(e);
            @(negedge clk);
            e = dexp_q.pop_front();
            checks++;
            if (d_sel !== e.sel) begin
                errors++;
                $display("FAIL deep[%0d] fwd_sel got=%h exp=%h", j, d_sel, e.sel);
            end
            checks++;
            if (d_stall !== e.st) begin
                errors++;
                $display("FAIL deep[%0d] hazard_stall got=%b exp=%b", j, d_stall, e.st);
            end
`ifdef FWD_STATS_EN
            if (j == 5) begin
                checks++;
                if (d_stall_cnt !== 32'd2) begin
                    errors++;
                    $display("FAIL deep stall_cnt got=%0d exp=2", d_stall_cnt);
                end
                checks++;
                if (d_fwd_cnt !== 32'd1) begin
                    errors++;
                    $display("FAIL deep fwd_cnt got=%0d exp=1", d_fwd_cnt);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; ev = 1'b0; we = 1'b0; ld = 1'b0;
        rd = '0; rs = '0; used = '0;
        d_hold = 1'b0; d_ev = 1'b0; d_we = 1'b0; d_ld = 1'b0;
        d_rd = '0; d_rs = '0; d_used = '0;
        @(posedge clk); #1;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_pipe_hold();
        test_mid_reset();
        test_deep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
